ram_nr1w_be: RTL and testbench

- Parametrised successor to the single-read/single-write block RAM.
- Provides NUM_RD independent read ports and one write port with byte enables.
- Write-first forwarding on read-during-write to the same address; optional output register stage; per-port read-valid flags.
- Hardware clear engine fills the whole array with CLEAR_VAL after reset or on request, so the pattern/test harness starts from a known memory state.

---
 rtl/ram_nr1w_be.sv | 148 ++++++++++++++
 tb/tb_ram_nr1w_be.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_nr1w_be.sv
// Multi-read, single-write RAM with byte enables, write-first forwarding,
// an optional output register and a hardware clear engine that fills the
// array with CLEAR_VAL after reset or on clr_req.

// One read lane: merges a same-edge write into the looked-up word, then
// carries data/valid through 1 (OUT_REG=0) or 2 (OUT_REG=1) register stages.
module ram_nr1w_be_rd_lane #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc,
  input  logic                fwd,
  input  logic [DATA_W-1:0]   mem_word,
  input  logic [DATA_W-1:0]   w_din,
  input  logic [DATA_W/8-1:0] w_be,
  output logic [DATA_W-1:0]   dout,
  output logic                valid
);
  localparam int NB     = DATA_W / 8;
  localparam int STAGES = (OUT_REG != 0) ? 1 : 0;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;
  logic [DATA_W-1:0]           rd_word;

  // Write-first: bytes being written this edge replace the stored ones.
  always_comb begin
    rd_word = mem_word;
    if (fwd)
      for (int k = 0; k < NB; k++)
        if (w_be[k]) rd_word[8*k +: 8] = w_din[8*k +: 8];
  end

  // Data stages only load on a valid read so dout holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= acc;
      if (acc) dat_pipe[0] <= rd_word;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign dout  = dat_pipe[STAGES];
  assign valid = vld_pipe[STAGES];
endmodule

module ram_nr1w_be #(
  parameter int              BLOCKSIZE = 10,
  parameter int              DATA_W    = 32,
  parameter int              NUM_RD    = 2,
  parameter int              OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  output logic                       init_done,
  input  logic                       w_enb,
  input  logic [BLOCKSIZE:0]         w_addr,
  input  logic [DATA_W-1:0]          w_din,
  input  logic [DATA_W/8-1:0]        w_be,
  input  logic [NUM_RD-1:0]          r_en,
  input  logic [NUM_RD*(BLOCKSIZE+1)-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0]   r_dout,
  output logic [NUM_RD-1:0]          r_valid
);
  localparam int AW    = BLOCKSIZE + 1;
  localparam int DEPTH = 1 << AW;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic            ready;
  logic            wr_act;

  assign ready     = (state == READY);
  assign wr_act    = ready & w_enb;
  assign init_done = ready;

  // Clear-engine state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Sweep every address once, then idle until the next clr_req.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (&clr_cnt) state_nxt = READY;
      end
      READY: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Single write port: clear engine owns it while clearing, else byte writes.
  always_ff @(posedge clk) begin
    if (!ready) mem[clr_cnt] <= CLEAR_VAL;
    else if (w_enb)
      for (int k = 0; k < NB; k++)
        if (w_be[k]) mem[w_addr][8*k +: 8] <= w_din[8*k +: 8];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = r_addr[i*AW +: AW];

    ram_nr1w_be_rd_lane #(
      .DATA_W  (DATA_W),
      .OUT_REG (OUT_REG)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .acc      (ready & r_en[i]),
      .fwd      (wr_act && (w_addr == ra)),
      .mem_word (mem[ra]),
      .w_din    (w_din),
      .w_be     (w_be),
      .dout     (r_dout[i*DATA_W +: DATA_W]),
      .valid    (r_valid[i])
    );
  end
endmodule

// File: tb/tb_ram_nr1w_be.sv
// Scoreboard bench for ram_nr1w_be: stimulus pushes expected read words with
// their due cycle; a negedge monitor pops one entry per r_valid strobe.
module tb_ram_nr1w_be;
  localparam int BLOCKSIZE = 10;
  localparam int AW        = BLOCKSIZE + 1;
  localparam int DATA_W    = 32;
  localparam int NUM_RD    = 2;
  localparam int OUT_REG   = 0;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     clr_req = 1'b0;
  logic                     init_done;
  logic                     w_enb = 1'b0;
  logic [AW-1:0]            w_addr = '0;
  logic [DATA_W-1:0]        w_din = '0;
  logic [DATA_W/8-1:0]      w_be = '0;
  logic [NUM_RD-1:0]        r_en = '0;
  logic [NUM_RD*AW-1:0]     r_addr = '0;
  logic [NUM_RD*DATA_W-1:0] r_dout;
  logic [NUM_RD-1:0]        r_valid;

  ram_nr1w_be #(
    .BLOCKSIZE (BLOCKSIZE),
    .DATA_W    (DATA_W),
    .NUM_RD    (NUM_RD),
    .OUT_REG   (OUT_REG),
    .CLEAR_VAL (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .init_done (init_done),
    .w_enb     (w_enb),
    .w_addr    (w_addr),
    .w_din     (w_din),
    .w_be      (w_be),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .r_dout    (r_dout),
    .r_valid   (r_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (r_valid[i]) begin
          exp_t e;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: port %0d data %0h at cycle %0d, expected no strobe",
                     i, r_dout[i*DATA_W +: DATA_W], cyc);
          end else begin
            e = sb.pop_front();
            chk("rd_port", 64'(i), 64'(e.port));
            chk("rd_data", 64'(r_dout[i*DATA_W +: DATA_W]), 64'(e.data));
            chk("rd_cycle", 64'(cyc), 64'(e.due));
          end
        end
      end
    end
  end

  // One cycle of stimulus; expected read results queued with their due cycle.
  task automatic op(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic [1:0] re,
                    input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                    input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    @(posedge clk); #1;
    w_enb = we; w_addr = wa; w_din = wd; w_be = be;
    r_en = re; r_addr = {a1, a0};
    if (re[0]) begin e.port = 0; e.data = e0; e.due = cyc + 1 + OUT_REG; sb.push_back(e); end
    if (re[1]) begin e.port = 1; e.data = e1; e.due = cyc + 1 + OUT_REG; sb.push_back(e); end
  endtask

  task automatic idle();
    op(1'b0, '0, '0, 4'h0, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    op(1'b1, a, d, be, 2'b00, '0, '0, '0, '0);
  endtask

  // Counts edges until init_done rises, bounded.
  task automatic wait_init(input string name, input int exp_n);
    int n;
    n = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  task automatic pulse_clr();
    idle();
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    chk("init_drop", 64'(init_done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r_dout", 64'(r_dout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_init("init_len", 2048);

    // Cleared array reads back zero, including the boundaries
    op(1'b0, '0, '0, 4'h0, 2'b11, 11'd0, 11'd1027, 32'h0, 32'h0);
    op(1'b0, '0, '0, 4'h0, 2'b01, 11'd2047, 11'd0, 32'h0, 32'h0);
    idle();

    // Byte-enable merge
    wr(11'd5, 32'hAABBCCDD, 4'hF);
    wr(11'd5, 32'h11223344, 4'b0101);
    op(1'b0, '0, '0, 4'h0, 2'b11, 11'd5, 11'd5, 32'hAA22CC44, 32'hAA22CC44);
    idle();

    // Read-during-write on both ports, then partial-byte forwarding
    op(1'b1, 11'd9, 32'hDEADBEEF, 4'hF, 2'b11, 11'd9, 11'd9, 32'hDEADBEEF, 32'hDEADBEEF);
    op(1'b1, 11'd5, 32'h00000000, 4'b1000, 2'b01, 11'd5, 11'd0, 32'h0022CC44, 32'h0);
    idle();

    // Independent ports, back-to-back
    wr(11'd2047, 32'hCAFEF00D, 4'hF);
    wr(11'd0, 32'h12345678, 4'hF);
    for (int i = 0; i < 8; i++)
      op(1'b0, '0, '0, 4'h0, 2'b11, 11'd2047, 11'd0, 32'hCAFEF00D, 32'h12345678);
    idle();

    // Fill 0..15, then clear on request; traffic during clear is ignored
    for (int i = 0; i < 16; i++) wr(AW'(i), 32'h5A5A5A5A, 4'hF);
    op(1'b0, '0, '0, 4'h0, 2'b01, 11'd3, 11'd0, 32'h5A5A5A5A, 32'h0);
    pulse_clr();
    w_enb = 1'b1; w_addr = 11'd3; w_din = 32'hFFFFFFFF; w_be = 4'hF;
    r_en = 2'b11; r_addr = {11'd4, 11'd3};
    wait_init("clr_len", 2048);
    w_enb = 1'b0; r_en = 2'b00;
    for (int i = 0; i < 16; i++)
      op(1'b0, '0, '0, 4'h0, 2'b11, AW'(i), AW'(15 - i), 32'h0, 32'h0);
    idle();

    // Reset in the middle of a clear
    wr(11'd7, 32'h0BADF00D, 4'hF);
    op(1'b0, '0, '0, 4'h0, 2'b11, 11'd7, 11'd2047, 32'h0BADF00D, 32'h0);
    idle();
    idle();
    pulse_clr();
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midclr_r_valid", 64'(r_valid), 64'd0);
    chk("midclr_r_dout", 64'(r_dout), 64'd0);
    chk("midclr_init_done", 64'(init_done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_init("reclear_len", 2048);
    op(1'b0, '0, '0, 4'h0, 2'b11, 11'd7, 11'd9, 32'h0, 32'h0);
    idle();

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
